// File: rtl/pwm_seq_pkg.sv
// rtl/pwm_seq_pkg.sv - shared types and default constants for the PWM step sequencer
package pwm_seq_pkg;

  localparam int PWM_SEQ_STEPS  = 8;
  localparam int PWM_SEQ_W      = 8;
  localparam int PWM_SEQ_HOLD_W = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } pwm_seq_state_t;

  typedef struct packed {
    logic [PWM_SEQ_W-1:0]      period;
    logic [PWM_SEQ_W-1:0]      duty;
    logic [PWM_SEQ_HOLD_W-1:0] hold;
  } pwm_seq_entry_t;

endpackage

// File: rtl/pwm_seq_table.sv
// rtl/pwm_seq_table.sv - flop-based step table, one write port, one combinational read port
module pwm_seq_table #(
  parameter int STEPS  = 8,
  parameter int W      = 8,
  parameter int HOLD_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(STEPS)-1:0] wr_addr,
  input  logic [W-1:0]             wr_period,
  input  logic [W-1:0]             wr_duty,
  input  logic [HOLD_W-1:0]        wr_hold,
  input  logic [$clog2(STEPS)-1:0] rd_addr,
  output logic [W-1:0]             rd_period,
  output logic [W-1:0]             rd_duty,
  output logic [HOLD_W-1:0]        rd_hold
);

  logic [W-1:0]      period_mem [STEPS];
  logic [W-1:0]      duty_mem   [STEPS];
  logic [HOLD_W-1:0] hold_mem   [STEPS];

  // Table storage: cleared on reset, written whenever the strobe is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STEPS; i++) begin
        period_mem[i] <= '0;
        duty_mem[i]   <= '0;
        hold_mem[i]   <= '0;
      end
    end else if (we) begin
      period_mem[wr_addr] <= wr_period;
      duty_mem[wr_addr]   <= wr_duty;
      hold_mem[wr_addr]   <= wr_hold;
    end
  end

  // Read is combinational so a same-cycle write is not yet visible (old value wins).
  always_comb begin
    rd_period = period_mem[rd_addr];
    rd_duty   = duty_mem[rd_addr];
    rd_hold   = hold_mem[rd_addr];
  end

endmodule

// File: rtl/pwm_sequencer.sv
// rtl/pwm_sequencer.sv - step-table sequencer for pwm_structural; PWM_SEQ_LOOP_EN wraps instead of finishing
module pwm_sequencer
  import pwm_seq_pkg::*;
#(
  parameter int STEPS  = PWM_SEQ_STEPS,
  parameter int W      = PWM_SEQ_W,
  parameter int HOLD_W = PWM_SEQ_HOLD_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_we,
  input  logic [$clog2(STEPS)-1:0] cfg_addr,
  input  logic [W-1:0]             cfg_period,
  input  logic [W-1:0]             cfg_duty,
  input  logic [HOLD_W-1:0]        cfg_hold,
  input  logic [$clog2(STEPS)-1:0] last_step,
  input  logic                     start,
  input  logic                     stop,
  output logic [W-1:0]             period,
  output logic [W-1:0]             duty,
  output logic                     enable,
  output logic [$clog2(STEPS)-1:0] step,
  output logic                     frame_end,
  output logic                     busy,
  output logic                     done
);

  localparam int AW = $clog2(STEPS);

  pwm_seq_state_t    state, state_n;
  logic [W-1:0]      cnt, cnt_n;
  logic [HOLD_W-1:0] frm, frm_n;
  logic [HOLD_W-1:0] hold_r, hold_n;
  logic [W-1:0]      period_n, duty_n;
  logic [AW-1:0]     step_n;
  logic              done_n, frame_end_n;
  logic              load, clear;

  logic [W-1:0]      eff_p_n;
  logic [HOLD_W-1:0] eff_h;
  logic              last_frame, seq_end;

  logic [AW-1:0]     rd_addr;
  logic [W-1:0]      rd_period, rd_duty;
  logic [HOLD_W-1:0] rd_hold;

  pwm_seq_table #(
    .STEPS  (STEPS),
    .W      (W),
    .HOLD_W (HOLD_W)
  ) u_table (
    .clk       (clk),
    .rst       (rst),
    .we        (cfg_we),
    .wr_addr   (cfg_addr),
    .wr_period (cfg_period),
    .wr_duty   (cfg_duty),
    .wr_hold   (cfg_hold),
    .rd_addr   (rd_addr),
    .rd_period (rd_period),
    .rd_duty   (rd_duty),
    .rd_hold   (rd_hold)
  );

  // End-of-step / end-of-sequence decode and which table entry would be entered next.
  always_comb begin
    eff_h      = (hold_r == '0) ? HOLD_W'(1) : hold_r;
    last_frame = (frm == eff_h - HOLD_W'(1));
    seq_end    = (step > last_step) || (last_frame && (step == last_step));
    rd_addr    = '0;
    if (state == RUN && !seq_end) begin
      rd_addr = step + AW'(1);
    end
  end

  // Next-state, counters and next output values; everything lands in registers.
  always_comb begin
    state_n  = state;
    step_n   = step;
    cnt_n    = cnt;
    frm_n    = frm;
    period_n = period;
    duty_n   = duty;
    hold_n   = hold_r;
    done_n   = 1'b0;
    load     = 1'b0;
    clear    = 1'b0;

    case (state)
      IDLE: begin
        if (start && !stop) begin
          state_n = RUN;
          load    = 1'b1;
        end
      end
      RUN: begin
        if (frame_end) begin
          if (stop) begin
            clear = 1'b1;
          end else if (seq_end) begin
`ifdef PWM_SEQ_LOOP_EN
            load = 1'b1;
`else
            clear  = 1'b1;
            done_n = 1'b1;
`endif
          end else if (last_frame) begin
            load = 1'b1;
          end else begin
            cnt_n = '0;
            frm_n = frm + HOLD_W'(1);
          end
        end else begin
          cnt_n = cnt + W'(1);
          if (stop) begin
            state_n = STOPPING;
          end
        end
      end
      STOPPING: begin
        if (frame_end) begin
          clear = 1'b1;
        end else begin
          cnt_n = cnt + W'(1);
        end
      end
      default: clear = 1'b1;
    endcase

    if (load) begin
      step_n   = rd_addr;
      period_n = rd_period;
      duty_n   = rd_duty;
      hold_n   = rd_hold;
      cnt_n    = '0;
      frm_n    = '0;
    end

    if (clear) begin
      state_n  = IDLE;
      step_n   = '0;
      period_n = '0;
      duty_n   = '0;
      hold_n   = '0;
      cnt_n    = '0;
      frm_n    = '0;
    end

    // frame_end is registered, so it is predicted from the next counter and period.
    eff_p_n     = (period_n == '0) ? W'(1) : period_n;
    frame_end_n = (state_n != IDLE) && (cnt_n == eff_p_n - W'(1));
  end

  // State and output registers; reset aborts everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      step      <= '0;
      cnt       <= '0;
      frm       <= '0;
      period    <= '0;
      duty      <= '0;
      hold_r    <= '0;
      enable    <= 1'b0;
      busy      <= 1'b0;
      frame_end <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      step      <= step_n;
      cnt       <= cnt_n;
      frm       <= frm_n;
      period    <= period_n;
      duty      <= duty_n;
      hold_r    <= hold_n;
      enable    <= (state_n != IDLE);
      busy      <= (state_n != IDLE);
      frame_end <= frame_end_n;
      done      <= done_n;
    end
  end

endmodule

// File: tb/tb_pwm_sequencer.sv
// tb/tb_pwm_sequencer.sv - randomized self-checking bench for pwm_sequencer against a step/cycle reference model
module tb_pwm_sequencer;
  import pwm_seq_pkg::*;

  localparam int STEPS = PWM_SEQ_STEPS;
  localparam int AW    = $clog2(STEPS);

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [7:0]    cfg_period, cfg_duty, cfg_hold;
  logic [AW-1:0] last_step;
  logic          start, stop;
  logic [7:0]    period, duty;
  logic          enable, frame_end, busy, done;
  logic [AW-1:0] step;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: current step, cycle index inside the step, captured entry.
  pwm_seq_entry_t mt [STEPS];
  bit m_busy, m_stopping, m_done;
  int m_step, m_cyc, m_p, m_d, m_h;

  pwm_sequencer dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_period(cfg_period), .cfg_duty(cfg_duty), .cfg_hold(cfg_hold),
    .last_step(last_step), .start(start), .stop(stop),
    .period(period), .duty(duty), .enable(enable), .step(step),
    .frame_end(frame_end), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int eff(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  function automatic bit m_fe();
    return m_busy && ((m_cyc % eff(m_p)) == eff(m_p) - 1);
  endfunction

  task automatic m_enter(input int i);
    m_busy = 1; m_stopping = 0; m_step = i; m_cyc = 0;
    m_p = int'(mt[i].period); m_d = int'(mt[i].duty); m_h = int'(mt[i].hold);
  endtask

  task automatic m_idle();
    m_busy = 0; m_stopping = 0; m_step = 0; m_cyc = 0; m_p = 0; m_d = 0; m_h = 0;
  endtask

  task automatic m_reset();
    for (int i = 0; i < STEPS; i++) mt[i] = '0;
    m_idle();
    m_done = 0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    int  ep, eh, ls;
    bit  fe, last;
    ep = eff(m_p); eh = eff(m_h); ls = int'(last_step);
    fe = m_fe();
    last = (m_cyc == ep * eh - 1);
    m_done = 0;
    if (!m_busy) begin
      if (start && !stop) m_enter(0);
    end else if (fe) begin
      if (m_stopping || stop) m_idle();
      else if (m_step > ls || (last && m_step == ls)) begin
`ifdef PWM_SEQ_LOOP_EN
        m_enter(0);
`else
        m_idle();
        m_done = 1;
`endif
      end else if (last) m_enter(m_step + 1);
      else m_cyc++;
    end else begin
      m_cyc++;
      if (stop) m_stopping = 1;
    end
    if (cfg_we) mt[int'(cfg_addr)] = '{period: cfg_period, duty: cfg_duty, hold: cfg_hold};
  endtask

  task automatic compare_all();
    check("period", int'(period), m_p);
    check("duty", int'(duty), m_d);
    check("enable", int'(enable), int'(m_busy));
    check("busy", int'(busy), int'(m_busy));
    check("step", int'(step), m_step);
    check("frame_end", int'(frame_end), int'(m_fe()));
    check("done", int'(done), int'(m_done));
  endtask

  task automatic tick(input bit we, input int a, input int p, input int d, input int h,
                      input bit st, input bit sp);
    cfg_we = we; cfg_addr = AW'(a); cfg_period = 8'(p); cfg_duty = 8'(d); cfg_hold = 8'(h);
    start = st; stop = sp;
    model_step();
    @(posedge clk);
    @(negedge clk);
    cfg_we = 1'b0; start = 1'b0; stop = 1'b0;
    compare_all();
  endtask

  task automatic idle_tick();
    tick(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr(input int a, input int p, input int d, input int h);
    tick(1, a, p, d, h, 0, 0);
  endtask

  task automatic drain();
    tick(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 600 && busy; i++) idle_tick();
    check("drain_idle", int'(busy), 0);
  endtask

  // Reset asserted between clock edges; outputs must clear without a clock.
  task automatic do_reset();
    #1 rst = 1'b1;
    #1 m_reset();
    check("rst_period", int'(period), 0);
    check("rst_enable", int'(enable), 0);
    check("rst_busy", int'(busy), 0);
    compare_all();
    #1 rst = 1'b0;
  endtask

  initial begin
    int c0, c1, nd, n;
    rst = 1'b1; cfg_we = 0; cfg_addr = '0; cfg_period = '0; cfg_duty = '0; cfg_hold = '0;
    last_step = '0; start = 0; stop = 0;
    m_reset();
    #3;
    compare_all();
    @(negedge clk);
    rst = 1'b0;
    idle_tick();

    // Basic two-step sequence.
    wr(0, 10, 5, 2); wr(1, 20, 15, 1); last_step = AW'(1);
    tick(0, 0, 0, 0, 0, 1, 0);
    c0 = 0; c1 = 0; nd = 0;
    for (int i = 0; i < 60; i++) begin
`ifdef PWM_SEQ_LOOP_EN
      if (i == 40) break;
`endif
      if (done) begin nd++; break; end
      if (busy && step == 0) c0++;
      if (busy && step == 1) c1++;
      idle_tick();
    end
    check("basic_step0_cycles", c0, 20);
    check("basic_step1_cycles", c1, 20);
`ifdef PWM_SEQ_LOOP_EN
    check("basic_done", nd, 0);
    drain();
`else
    check("basic_done", nd, 1);
    check("basic_enable_off", int'(enable), 0);
`endif
    idle_tick();

    // Start and stop together: stop wins.
    tick(0, 0, 0, 0, 0, 1, 1);
    check("start_stop_idle", int'(busy), 0);

    // Stop three cycles into a 10-cycle frame.
    wr(0, 10, 5, 3); last_step = AW'(0);
    tick(0, 0, 0, 0, 0, 1, 0);
    idle_tick(); idle_tick(); idle_tick();
    tick(0, 0, 0, 0, 0, 0, 1);
    n = 1;
    while (n < 50 && busy) begin idle_tick(); n++; end
    check("stop_latency", n, 7);
    check("stop_no_done", int'(done), 0);
    idle_tick();

    // Degenerate entry: period 0, hold 0 gives a one-cycle step.
    wr(0, 0, 9, 0); last_step = AW'(0);
    tick(0, 0, 0, 0, 0, 1, 0);
    check("degen_fe", int'(frame_end), 1);
    idle_tick();
`ifdef PWM_SEQ_LOOP_EN
    check("degen_loop_busy", int'(busy), 1);
    drain();
`else
    check("degen_len", int'(busy), 0);
    check("degen_done", int'(done), 1);
`endif
    wr(0, 100, 200, 1);
    tick(0, 0, 0, 0, 0, 1, 0);
    check("sat_duty", int'(duty), 200);
    drain();

    // Live write to the active step takes effect only on re-entry.
    wr(0, 10, 5, 1); wr(1, 3, 3, 1); last_step = AW'(1);
    tick(0, 0, 0, 0, 0, 1, 0);
    idle_tick(); idle_tick();
    tick(1, 0, 50, 5, 1, 0, 0);
    check("live_keep", int'(period), 10);
`ifdef PWM_SEQ_LOOP_EN
    for (n = 0; n < 100 && step != 1; n++) idle_tick();
    for (n = 0; n < 100 && step != 0; n++) idle_tick();
    check("live_reentry", int'(period), 50);
`else
    for (n = 0; n < 100 && busy; n++) idle_tick();
    tick(0, 0, 0, 0, 0, 1, 0);
    check("live_reentry", int'(period), 50);
`endif
    drain();

    // Reset during step 1, then run the cleared table.
    wr(0, 10, 5, 2); wr(1, 20, 15, 1); last_step = AW'(1);
    tick(0, 0, 0, 0, 0, 1, 0);
    for (n = 0; n < 60 && step != 1; n++) idle_tick();
    idle_tick(); idle_tick();
    check("rst_pre_step", int'(step), 1);
    do_reset();
    tick(0, 0, 0, 0, 0, 1, 0);
    check("rst_entry0_period", int'(period), 0);
    check("rst_entry0_fe", int'(frame_end), 1);
    drain();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) last_step = AW'($urandom_range(0, STEPS - 1));
      if ($urandom_range(0, 799) == 0) do_reset();
      tick($urandom_range(0, 3) == 0, int'($urandom_range(0, STEPS - 1)),
           int'($urandom_range(0, 12)), int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
           $urandom_range(0, 19) == 0, $urandom_range(0, 59) == 0);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_sequencer.md
# pwm_sequencer

Controller that drives the `period`/`duty`/`enable` inputs of a `pwm_structural` instance from a small programmable step table. Each step holds a (period, duty, hold) triple and is played for `hold` complete PWM frames. Changes take effect only on PWM frame boundaries, so the PWM output never sees a mid-frame reconfiguration. The block sits between the host register interface and the PWM datapath.

## Interface
Parameters:
- `STEPS`, 8 — table depth; power of two, ≥ 2.
- `W`, 8 — width of period/duty; matches the PWM datapath.
- `HOLD_W`, 8 — width of the per-step frame-repeat count.

Ports:
- `clk` in 1 — single clock for the whole block.
- `rst` in 1 — reset; asynchronous, active-high.
- `cfg_we` in 1 — table write strobe.
- `cfg_addr` in $clog2(STEPS) — table write address.
- `cfg_period` in W — period value to write.
- `cfg_duty` in W — duty value to write.
- `cfg_hold` in HOLD_W — hold count to write.
- `last_step` in $clog2(STEPS) — index of the final step in the sequence.
- `start` in 1 — single-cycle pulse that begins the sequence.
- `stop` in 1 — single-cycle pulse that ends the sequence at the next frame boundary.
- `period` out W — to `pwm_structural.period`.
- `duty` out W — to `pwm_structural.duty`.
- `enable` out 1 — to `pwm_structural.enable`.
- `step` out $clog2(STEPS) — index of the active step.
- `frame_end` out 1 — one-cycle pulse on the last clock of each PWM frame.
- `busy` out 1 — high in RUN and STOPPING.
- `done` out 1 — one-cycle pulse when the sequence ends naturally.

## Operation
- **Table:** `STEPS` entries held in flops.
  - Combinational read.
  - Writes are accepted in any state.
- **Active registers:** `period`, `duty` and `hold_r` are captured from the table at step entry.
  - Table writes to the active step do not affect it until that step is re-entered.
- **Effective frame length:** `eff_p = (period == 0) ? 1 : period`.
- **Effective hold:** `eff_h = (hold_r == 0) ? 1 : hold_r`.
- **Duty:** `duty > period` is passed through unchanged; the PWM saturates.
- **Counters:**
  - `cnt` (W bits) runs 0..eff_p−1.
  - `frm` (HOLD_W bits) runs 0..eff_h−1.
  - Both clear on step entry.
- **States:**
  - **IDLE.**
    - `start` & !`stop` → capture entry 0, go to RUN.
    - `start` & `stop` together → stay in IDLE (stop wins).
  - **RUN.**
    - At `cnt == eff_p−1`: `frame_end` = 1.
    - If `frm == eff_h−1`, advance to step `step+1`.
    - If `step == last_step`, apply the end-of-sequence rule instead (see Configuration).
    - `stop` → STOPPING.
    - `start` is ignored.
  - **STOPPING.** Continue the current frame. At `frame_end`, go to IDLE with no `done` pulse.
- **Other rules:**
  - `last_step` is sampled live.
  - If `step > last_step` when it is checked, the sequence ends at that frame boundary.
  - Reset during any state aborts immediately: table, counters and outputs all go to zero, state goes to IDLE.

## Timing
- Reset values: `period`=0, `duty`=0, `enable`=0, `step`=0, `frame_end`=0, `busy`=0, `done`=0; table cleared.
- `start` sampled in cycle t → in cycle t+1, `enable`=1, `busy`=1, `period`/`duty` = entry 0, `cnt`=0.
- Step duration is exactly eff_p × eff_h cycles.
- New step values appear in the cycle after `frame_end`.
- A `cfg_we` in the same cycle as a step entry at the same address: the old value is captured.
- End of sequence, in the cycle after the final `frame_end`:
  - `enable`=0, `busy`=0, `period`=`duty`=0, `step`=0.
  - `done`=1 for that one cycle.
- All outputs are registered.

## Configuration
- `PWM_SEQ_LOOP_EN` defined:
  - After `last_step` completes, wrap to step 0 and stay in RUN.
  - `done` never pulses; only `stop` or `rst` ends the sequence.
- `PWM_SEQ_LOOP_EN` undefined: after `last_step` completes, return to IDLE with a `done` pulse.

## Structure
- Package `pwm_seq_pkg` contains:
  - the state enum `pwm_seq_state_t` (IDLE, RUN, STOPPING);
  - the entry struct `pwm_seq_entry_t` {period, duty, hold};
  - the default parameter constants.
- Sub-module `pwm_seq_table` provides the flop array, one write port and one combinational read port.
- The FSM and counters live in the top module.

## Test plan
- **Basic sequence:** entries {10,5,2},{20,15,1}, `last_step`=1, `start` → `step`=0 for 20 cycles with `period`=10/`duty`=5, then `step`=1 for 20 cycles with `period`=20/`duty`=15, then a `done` pulse and `enable`=0.
- **Stop mid-frame:** `stop` issued 3 cycles into a frame with `period`=10 → `busy` drops exactly 7 cycles later; no `done` pulse.
- **Degenerate entries:** period=0, hold=0 → step lasts 1 cycle; duty=200 with period=100 → duty is output as 200.
- **Live write to the active step:** write entry 0 to period=50 while step 0 is running → the current step keeps period 10; the new value appears on re-entry (loop build).
- **Loop build (`PWM_SEQ_LOOP_EN`):** `last_step`=1 → `step` cycles 0,1,0,1,… and `done` stays 0.
- **Reset mid-run:** assert `rst` during step 1 → all outputs are 0 asynchronously, the table reads zero, and a following `start` runs entry 0 = {0,0,0}.
